audio_sample_feeder: RTL
========================

// Module: audio_sample_feeder
// PURPOSE
//  Buffers 24-bit PCM samples between the sample source (SDRAM/on-chip loader) and the I2S
//  serializer. The source pushes with a valid/ready handshake. The serializer pulls one sample
//  per rising edge of its Read strobe; Read may stay high for several Clk cycles.
//  Primes before playback and delivers silence on underrun. Playback never stalls.
// PARAMETERS
//  WIDTH        24  sample width in bits
//  DEPTH_LOG2   4   FIFO depth = 2**DEPTH_LOG2 entries (16)
//  PRIME_LEVEL  8   occupancy needed to enter RUN; legal range 1..2**DEPTH_LOG2
// PORTS
//  Clk        in   1           single system clock; serializer Read is synchronous to it
//  Reset      in   1           asynchronous, active-low reset
//  Enable     in   1           playback enable; low = flush and idle
//  WrData     in   WIDTH       sample from source
//  WrValid    in   1           WrData valid
//  WrReady    out  1           feeder can accept; push happens when WrValid & WrReady
//  Read       in   1           serializer request, level; one pop per 0->1 edge
//  DataOut    out  WIDTH       registered sample to serializer DataIn
//  AudioEn    out  1           high in RUN; drives serializer AudioEn
//  Underrun   out  1           1-cycle pulse when a pop finds the FIFO empty in RUN
//  Level      out  DEPTH_LOG2+1  current occupancy, 0..2**DEPTH_LOG2
// BEHAVIOUR
//  Reset (Reset=0, async): state=IDLE, ptrs=0, Level=0, DataOut=0, AudioEn=0, Underrun=0,
//    WrReady=0, Read edge-detect register=0. Outputs follow state on the next Clk edge after release.
//  Pop edge: pop_req = Read & ~Read_q. Read_q is registered every cycle.
//  States:
//   IDLE: WrReady=0; ptrs/Level held at 0; DataOut=0. Enable=1 -> PRIME next cycle.
//   PRIME: WrReady=~full; pop_req loads DataOut=0 and does not pop.
//     Level>=PRIME_LEVEL (evaluated after this cycle's push) -> RUN.
//   RUN: AudioEn=1; WrReady=~full.
//     pop_req & ~empty -> DataOut<=mem[rd_ptr], rd_ptr++ (1-cycle latency from Read rise).
//     pop_req & empty -> DataOut<=0, Underrun pulse, -> PRIME.
//   Enable=0 in any state -> IDLE next cycle. Flush ptrs/Level and DataOut<=0.
//     Any push in that cycle is dropped.
//  Arithmetic: wr_ptr/rd_ptr are DEPTH_LOG2 bits and wrap modulo depth.
//    Level is a separate DEPTH_LOG2+1 counter. full = Level==2**DEPTH_LOG2; empty = Level==0.
//  Simultaneous push & pop (RUN, not empty): both occur; Level unchanged; mem write and read on distinct slots.
//    Push & pop with Level==0: the pop sees empty (no fall-through) -> underrun path.
//  Full: WrReady=0, so WrValid is ignored. A pop in that same cycle does not enable a same-cycle push.
//  DataOut holds between pops and changes only on pop_req, flush or reset.
//  Read held high across a state change yields no extra pop until it falls and rises again.
// CONFIGURATION
//  AUDIO_FEEDER_STATS_EN defined: adds output UnderrunCount[15:0].
//    Increments on each Underrun pulse and saturates at 16'hFFFF.
//    Cleared by reset and by Enable=0.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset=0 mid-stream with Level=5 -> immediately DataOut=0, AudioEn=0, WrReady=0, Level=0.
//  2 Enable=1, push 8 samples 0x000001..0x000008 -> AudioEn rises the cycle after the 8th push.
//    Earlier Read pulses give DataOut=0.
//  3 RUN, Read high for 7 cycles, then low, then high again -> exactly two pops.
//    DataOut=0x000001 then 0x000002, each one cycle after its Read rise.
//  4 Push 16 with no pops -> WrReady=0 at Level=16 and the 17th WrValid is dropped.
//    Pop/push across 3 full wraps -> data order intact.
//  5 RUN, drain to empty, then Read rise -> DataOut=0, Underrun 1 cycle, AudioEn=0.
//    Re-enters RUN after Level reaches 8. With AUDIO_FEEDER_STATS_EN, UnderrunCount=1.
//  6 Simultaneous push & pop at Level=4 -> Level stays 4; popped value is the oldest sample.

Source files
------------

// File: rtl/audio_sample_feeder_if.sv
// rtl/audio_sample_feeder_if.sv - handshake/bus bundle between feeder, sample source and I2S serializer
//
// Signals (all synchronous to the feeder clock):
//   Enable        playback enable; low flushes the feeder
//   WrData        sample from source
//   WrValid       WrData valid
//   WrReady       feeder can accept a sample
//   Read          serializer pull request, level; one pop per rising edge
//   DataOut       registered sample to serializer
//   AudioEn       playback running
//   Underrun      one-cycle pulse when a pop finds the buffer empty
//   Level         current occupancy
//   UnderrunCount saturating underrun counter (only with AUDIO_FEEDER_STATS_EN)
// Modports: master = source/serializer side, slave = feeder side.

interface audio_sample_feeder_if #(
    parameter int WIDTH      = 24,
    parameter int DEPTH_LOG2 = 4
);
    logic                  Enable;
    logic [WIDTH-1:0]      WrData;
    logic                  WrValid;
    logic                  WrReady;
    logic                  Read;
    logic [WIDTH-1:0]      DataOut;
    logic                  AudioEn;
    logic                  Underrun;
    logic [DEPTH_LOG2:0]   Level;
`ifdef AUDIO_FEEDER_STATS_EN
    logic [15:0]           UnderrunCount;

    modport master (
        output Enable, WrData, WrValid, Read,
        input  WrReady, DataOut, AudioEn, Underrun, Level, UnderrunCount
    );

    modport slave (
        input  Enable, WrData, WrValid, Read,
        output WrReady, DataOut, AudioEn, Underrun, Level, UnderrunCount
    );
`else
    modport master (
        output Enable, WrData, WrValid, Read,
        input  WrReady, DataOut, AudioEn, Underrun, Level
    );

    modport slave (
        input  Enable, WrData, WrValid, Read,
        output WrReady, DataOut, AudioEn, Underrun, Level
    );
`endif
endinterface

// File: rtl/audio_sample_feeder.sv
// rtl/audio_sample_feeder.sv - PCM sample buffer between sample source and I2S serializer
//
// Buffers WIDTH-bit samples in a 2**DEPTH_LOG2 entry FIFO. The source pushes with
// WrValid/WrReady; the serializer pops one sample per rising edge of Read.
// The feeder primes to PRIME_LEVEL entries before playback (AudioEn) and answers
// a pop on an empty buffer with silence plus an Underrun pulse, then re-primes.
//
// Ports:
//   Clk    single system clock
//   Reset  asynchronous, active-low reset
//   bus    audio_sample_feeder_if.slave (Enable, WrData, WrValid, WrReady, Read,
//          DataOut, AudioEn, Underrun, Level[, UnderrunCount])
//
// Optional feature: define AUDIO_FEEDER_STATS_EN to add the saturating
// UnderrunCount output; undefined leaves the port and counter out entirely.

module audio_sample_feeder #(
    parameter int WIDTH       = 24,
    parameter int DEPTH_LOG2  = 4,
    parameter int PRIME_LEVEL = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    audio_sample_feeder_if.slave   bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PRIME_LVL  = (DEPTH_LOG2+1)'(PRIME_LEVEL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [DEPTH_LOG2:0]    level;
    logic [DEPTH_LOG2:0]    level_after_push;
    logic [WIDTH-1:0]       data_out;
    logic                   underrun;
    logic                   read_q;

    logic                   full;
    logic                   empty;
    logic                   pop_req;
    logic                   wr_ready;
    logic                   audio_en;
    logic                   do_push;
    logic                   do_pop;
    logic                   dout_clear;
    logic                   underrun_set;
    logic                   flush;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    // Read is a level; only its rising edge requests a sample.
    assign pop_req = bus.Read & ~read_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        wr_ready         = 1'b0;
        audio_en         = 1'b0;
        do_push          = 1'b0;
        do_pop           = 1'b0;
        dout_clear       = 1'b0;
        underrun_set     = 1'b0;
        flush            = 1'b0;
        level_after_push = level;

        // Ready and AudioEn depend only on registered state so the source
        // never sees ready rise because of a pop in the same cycle.
        wr_ready = (state != IDLE) && !full;
        audio_en = (state == RUN);

        if (!bus.Enable) begin
            // Flush wins over everything, including a push offered this cycle.
            state_next = IDLE;
            flush      = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    flush      = 1'b1;
                    state_next = PRIME;
                end
                PRIME: begin
                    do_push          = bus.WrValid & wr_ready;
                    level_after_push = level + {{DEPTH_LOG2{1'b0}}, do_push};
                    if (pop_req) begin
                        dout_clear = 1'b1;
                    end
                    if (level_after_push >= PRIME_LVL) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    do_push = bus.WrValid & wr_ready;
                    if (pop_req) begin
                        // Emptiness is judged on the registered level, so a
                        // concurrent push never falls through to the output.
                        if (empty) begin
                            dout_clear   = 1'b1;
                            underrun_set = 1'b1;
                            state_next   = PRIME;
                        end else begin
                            do_pop = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    flush      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            data_out <= '0;
            underrun <= 1'b0;
            read_q   <= 1'b0;
        end else begin
            read_q   <= bus.Read;
            underrun <= underrun_set;
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                data_out <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    data_out <= mem[rd_ptr];
                end else if (dout_clear) begin
                    data_out <= '0;
                end
                // Push and pop together leave the occupancy unchanged.
                if (do_push && !do_pop) begin
                    level <= level + 1'b1;
                end else if (do_pop && !do_push) begin
                    level <= level - 1'b1;
                end
            end
        end
    end

    // Storage has no reset; occupancy and pointers define which slots are live.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.WrData;
        end
    end

`ifdef AUDIO_FEEDER_STATS_EN
    logic [15:0] underrun_count;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            underrun_count <= '0;
        end else if (!bus.Enable) begin
            underrun_count <= '0;
        end else if (underrun_set && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end

    assign bus.UnderrunCount = underrun_count;
`endif

    assign bus.WrReady  = wr_ready;
    assign bus.AudioEn  = audio_en;
    assign bus.DataOut  = data_out;
    assign bus.Underrun = underrun;
    assign bus.Level    = level;

endmodule
